// File: rtl/sd_spi_target.sv
// sd_spi_target: SPI mode-0 card-side target for an emulated SD card.
// Oversamples ck/mosi/cs on the system clock, frames 6-byte SD commands for
// the backend over valid/ready and streams response bytes from a small FIFO.
// Build macro SD_SPI_TARGET_CRC7_EN: when defined, CRC7 is computed over frame
// bytes 0..4 and compared with the received CRC; otherwise cmd_crc_ok reads 1.
module sd_spi_target #(
  parameter int RSP_DEPTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        cs,
  input  logic        ck,
  input  logic        mosi,
  output logic        miso,
  output logic [7:0]  rx_byte,
  output logic        rx_stb,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [5:0]  cmd_idx,
  output logic [31:0] cmd_arg,
  output logic [6:0]  cmd_crc,
  output logic        cmd_crc_ok,
  output logic        cmd_ovr,
  input  logic        rsp_wr,
  input  logic [7:0]  rsp_d,
  output logic        rsp_full
);
  localparam int AW = $clog2(RSP_DEPTH);
  localparam logic [0:0]    ST_HUNT  = 1'b0;
  localparam logic [0:0]    ST_CMD   = 1'b1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(RSP_DEPTH);

`ifdef SD_SPI_TARGET_CRC7_EN
  // CRC7, polynomial x^7+x^3+1, one byte MSB-first
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) begin
        c = c ^ 7'h09;
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  logic [6:0] crc_acc_q, crc_acc_d;
`endif

  logic [SYNC_STAGES-1:0] ck_sync_q, ck_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
  logic        ck_prev_q, ck_prev_d, cs_prev_q, cs_prev_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d, n_q, n_d;
  logic [7:0]  rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, rx_byte_q, rx_byte_d;
  logic        miso_q, miso_d, rx_stb_q, rx_stb_d, cmd_valid_q, cmd_valid_d;
  logic        cmd_crc_ok_q, cmd_crc_ok_d, cmd_ovr_q, cmd_ovr_d;
  logic [0:0]  state_q, state_d;
  logic [5:0]  idx_buf_q, idx_buf_d, cmd_idx_q, cmd_idx_d;
  logic [31:0] arg_buf_q, arg_buf_d, cmd_arg_q, cmd_arg_d;
  logic [6:0]  cmd_crc_q, cmd_crc_d;
  logic [7:0]  mem_q [RSP_DEPTH];
  logic [7:0]  mem_d [RSP_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic       ck_s, cs_s, mosi_s, ck_rise_s, ck_fall_s;
  logic       load_s, byte_done_s, push_s, pop_s;
  logic [7:0] byte_s;

  assign ck_s      = ck_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ck_rise_s = ck_s & ~ck_prev_q;
  assign ck_fall_s = ~ck_s & ck_prev_q;
  assign byte_s    = {rx_sh_q[6:0], mosi_s};

  // Next-state logic: pin sync, bit/byte engine, frame FSM, response FIFO
  always_comb begin
    ck_sync_d = ck_sync_q;  cs_sync_d = cs_sync_q;  mosi_sync_d = mosi_sync_q;
    ck_prev_d = ck_prev_q;  cs_prev_d = cs_prev_q;
    bit_cnt_d = bit_cnt_q;  rx_sh_d = rx_sh_q;  tx_sh_d = tx_sh_q;
    rx_byte_d = rx_byte_q;  rx_stb_d = 1'b0;  cmd_ovr_d = 1'b0;
    cmd_valid_d = cmd_valid_q;  cmd_idx_d = cmd_idx_q;  cmd_arg_d = cmd_arg_q;
    cmd_crc_d = cmd_crc_q;  cmd_crc_ok_d = cmd_crc_ok_q;
    state_d = state_q;  n_d = n_q;  idx_buf_d = idx_buf_q;  arg_buf_d = arg_buf_q;
`ifdef SD_SPI_TARGET_CRC7_EN
    crc_acc_d = crc_acc_q;
`endif
    mem_d = mem_q;  wr_ptr_d = wr_ptr_q;  rd_ptr_d = rd_ptr_q;  count_d = count_q;
    load_s = 1'b0;  byte_done_s = 1'b0;  push_s = 1'b0;  pop_s = 1'b0;

    if (ce) begin
      ck_sync_d   = {ck_sync_q[SYNC_STAGES-2:0], ck};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ck_prev_d   = ck_s;
      cs_prev_d   = cs_s;

      // Backend handshake retires the pending frame; a new frame may reload below
      if (cmd_valid_q && cmd_ready) begin
        cmd_valid_d = 1'b0;
      end else begin
        cmd_valid_d = cmd_valid_q;
      end

      if (cs_s) begin
        bit_cnt_d = 3'd0;
        tx_sh_d   = 8'hFF;
        state_d   = ST_HUNT;
        n_d       = 3'd0;
      end else if (cs_prev_q) begin
        load_s = 1'b1;
      end else if (ck_rise_s) begin
        rx_sh_d = byte_s;
        if (bit_cnt_q == 3'd7) begin
          bit_cnt_d   = 3'd0;
          rx_byte_d   = byte_s;
          rx_stb_d    = 1'b1;
          load_s      = 1'b1;
          byte_done_s = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end else if (ck_fall_s && (bit_cnt_q != 3'd0)) begin
        tx_sh_d = {tx_sh_q[6:0], 1'b1};
      end else begin
        tx_sh_d = tx_sh_q;
      end

      // Pop decision uses the pre-push count so a same-cycle push into an empty FIFO is kept
      push_s = rsp_wr && (count_q != CNT_FULL);
      pop_s  = load_s && (count_q != '0);
      if (load_s) begin
        tx_sh_d = pop_s ? mem_q[rd_ptr_q] : 8'hFF;
      end else begin
        tx_sh_d = tx_sh_d;
      end
      if (push_s) begin
        mem_d[wr_ptr_q] = rsp_d;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase

      if (byte_done_s) begin
        case (state_q)
          ST_HUNT: begin
            if (byte_s[7:6] == 2'b01) begin
              state_d   = ST_CMD;
              n_d       = 3'd1;
              idx_buf_d = byte_s[5:0];
`ifdef SD_SPI_TARGET_CRC7_EN
              crc_acc_d = crc7_byte(7'h00, byte_s);
`endif
            end else begin
              state_d = ST_HUNT;
            end
          end
          ST_CMD: begin
            if (n_q == 3'd5) begin
              state_d = ST_HUNT;
              n_d     = 3'd0;
              if (!cmd_valid_q || cmd_ready) begin
                cmd_valid_d = 1'b1;
                cmd_idx_d   = idx_buf_q;
                cmd_arg_d   = arg_buf_q;
                cmd_crc_d   = byte_s[7:1];
`ifdef SD_SPI_TARGET_CRC7_EN
                cmd_crc_ok_d = (crc_acc_q == byte_s[7:1]);
`else
                cmd_crc_ok_d = 1'b1;
`endif
              end else begin
                cmd_ovr_d = 1'b1;
              end
            end else begin
              n_d       = n_q + 3'd1;
              arg_buf_d = {arg_buf_q[23:0], byte_s};
`ifdef SD_SPI_TARGET_CRC7_EN
              crc_acc_d = crc7_byte(crc_acc_q, byte_s);
`endif
            end
          end
          default: state_d = ST_HUNT;
        endcase
      end else begin
        state_d = state_d;
      end
    end else begin
      ck_sync_d = ck_sync_q;
    end
    miso_d = tx_sh_d[7];
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ck_sync_q <= '0;  cs_sync_q <= '1;  mosi_sync_q <= '0;
      ck_prev_q <= 1'b0;  cs_prev_q <= 1'b1;
      bit_cnt_q <= 3'd0;  rx_sh_q <= 8'h00;  tx_sh_q <= 8'hFF;
      miso_q <= 1'b1;  rx_byte_q <= 8'h00;  rx_stb_q <= 1'b0;
      cmd_valid_q <= 1'b0;  cmd_idx_q <= 6'd0;  cmd_arg_q <= 32'd0;
      cmd_crc_q <= 7'd0;  cmd_crc_ok_q <= 1'b0;  cmd_ovr_q <= 1'b0;
      state_q <= ST_HUNT;  n_q <= 3'd0;  idx_buf_q <= 6'd0;  arg_buf_q <= 32'd0;
`ifdef SD_SPI_TARGET_CRC7_EN
      crc_acc_q <= 7'd0;
`endif
      for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= '0;  rd_ptr_q <= '0;  count_q <= '0;
    end else begin
      ck_sync_q <= ck_sync_d;  cs_sync_q <= cs_sync_d;  mosi_sync_q <= mosi_sync_d;
      ck_prev_q <= ck_prev_d;  cs_prev_q <= cs_prev_d;
      bit_cnt_q <= bit_cnt_d;  rx_sh_q <= rx_sh_d;  tx_sh_q <= tx_sh_d;
      miso_q <= miso_d;  rx_byte_q <= rx_byte_d;  rx_stb_q <= rx_stb_d;
      cmd_valid_q <= cmd_valid_d;  cmd_idx_q <= cmd_idx_d;  cmd_arg_q <= cmd_arg_d;
      cmd_crc_q <= cmd_crc_d;  cmd_crc_ok_q <= cmd_crc_ok_d;  cmd_ovr_q <= cmd_ovr_d;
      state_q <= state_d;  n_q <= n_d;  idx_buf_q <= idx_buf_d;  arg_buf_q <= arg_buf_d;
`ifdef SD_SPI_TARGET_CRC7_EN
      crc_acc_q <= crc_acc_d;
`endif
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;  count_q <= count_d;
    end
  end

  assign miso       = miso_q;
  assign rx_byte    = rx_byte_q;
  assign rx_stb     = rx_stb_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_idx    = cmd_idx_q;
  assign cmd_arg    = cmd_arg_q;
  assign cmd_crc    = cmd_crc_q;
  assign cmd_crc_ok = cmd_crc_ok_q;
  assign cmd_ovr    = cmd_ovr_q;
  assign rsp_full   = (count_q == CNT_FULL);
endmodule

// File: tb/tb_sd_spi_target.sv
// Directed testbench for sd_spi_target: drives SPI mode-0 host traffic on the
// pins and checks framed commands, response FIFO output and reset behaviour.
module tb_sd_spi_target;
  logic        clock = 1'b0, reset = 1'b0, ce = 1'b1, cs = 1'b1, ck = 1'b0, mosi = 1'b0;
  logic        cmd_ready = 1'b1, rsp_wr = 1'b0;
  logic [7:0]  rsp_d = 8'h00;
  logic        miso, rx_stb, cmd_valid, cmd_crc_ok, cmd_ovr, rsp_full;
  logic [7:0]  rx_byte;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;

  int n_cmp = 0, n_bad = 0;
  int frames = 0, valid_cycles = 0, ovr_cnt = 0, stb_cnt = 0;
  logic valid_prev = 1'b0;

`ifdef SD_SPI_TARGET_CRC7_EN
  localparam logic BAD_CRC_OK = 1'b0;
`else
  localparam logic BAD_CRC_OK = 1'b1;
`endif

  sd_spi_target #(.RSP_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .ce(ce), .cs(cs), .ck(ck), .mosi(mosi), .miso(miso),
    .rx_byte(rx_byte), .rx_stb(rx_stb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .cmd_crc(cmd_crc), .cmd_crc_ok(cmd_crc_ok),
    .cmd_ovr(cmd_ovr), .rsp_wr(rsp_wr), .rsp_d(rsp_d), .rsp_full(rsp_full)
  );

  always #5 clock = ~clock;

  // Event counters sampled on the falling system-clock edge
  always @(negedge clock) begin
    valid_prev <= cmd_valid;
    if (cmd_valid) valid_cycles <= valid_cycles + 1;
    if (cmd_valid && !valid_prev) frames <= frames + 1;
    if (cmd_ovr) ovr_cnt <= ovr_cnt + 1;
    if (rx_stb) stb_cnt <= stb_cnt + 1;
  end

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'hFF;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      repeat (8) @(negedge clock);
      rx[7-i] = miso;
      ck = 1'b1;
      repeat (8) @(negedge clock);
      ck = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic cs_high();
    repeat (8) @(negedge clock);
    cs = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic send_frame(input logic [47:0] fr);
    logic [7:0] r;
    for (int i = 0; i < 6; i++) spi_xfer(fr[47-8*i -: 8], 8, r);
    repeat (4) @(negedge clock);
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clock);
    rsp_wr = 1'b1; rsp_d = b;
    @(negedge clock);
    rsp_wr = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (miso !== 1'b1) begin n_bad++; $display("FAIL reset_miso got %b want 1", miso); end
    n_cmp++; if (rx_byte !== 8'h00 || rx_stb !== 1'b0) begin n_bad++; $display("FAIL reset_rx got %h/%b want 00/0", rx_byte, rx_stb); end
    n_cmp++; if (cmd_valid !== 1'b0 || cmd_ovr !== 1'b0 || cmd_crc_ok !== 1'b0) begin n_bad++; $display("FAIL reset_cmdflags got %b%b%b want 000", cmd_valid, cmd_ovr, cmd_crc_ok); end
    n_cmp++; if (cmd_idx !== 6'd0 || cmd_arg !== 32'd0 || cmd_crc !== 7'd0) begin n_bad++; $display("FAIL reset_fields got %h %h %h want 0 0 0", cmd_idx, cmd_arg, cmd_crc); end
    n_cmp++; if (rsp_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", rsp_full); end
  endtask

  task automatic test_cmd0_cmd8();
    int f0, v0, s0;
    f0 = frames; v0 = valid_cycles; s0 = stb_cnt;
    cmd_ready = 1'b1;
    cs_low();
    send_frame(48'h40_00000000_95);
    n_cmp++; if (frames - f0 !== 1) begin n_bad++; $display("FAIL cmd0_frames got %0d want 1", frames - f0); end
    n_cmp++; if (valid_cycles - v0 !== 1) begin n_bad++; $display("FAIL cmd0_valid_len got %0d want 1", valid_cycles - v0); end
    n_cmp++; if (cmd_idx !== 6'd0 || cmd_arg !== 32'd0) begin n_bad++; $display("FAIL cmd0_fields got %h %h want 00 00000000", cmd_idx, cmd_arg); end
    n_cmp++; if (cmd_crc !== 7'h4A || cmd_crc_ok !== 1'b1) begin n_bad++; $display("FAIL cmd0_crc got %h/%b want 4a/1", cmd_crc, cmd_crc_ok); end
    n_cmp++; if (stb_cnt - s0 !== 6 || rx_byte !== 8'h95) begin n_bad++; $display("FAIL cmd0_rx got %0d/%h want 6/95", stb_cnt - s0, rx_byte); end
    // back-to-back in the same select: good CMD8 then corrupted CMD8
    send_frame(48'h48_000001AA_87);
    n_cmp++; if (cmd_idx !== 6'd8 || cmd_arg !== 32'h1AA || cmd_crc_ok !== 1'b1) begin n_bad++; $display("FAIL cmd8_good got %h %h %b want 08 000001aa 1", cmd_idx, cmd_arg, cmd_crc_ok); end
    send_frame(48'h48_000001AA_89);
    n_cmp++; if (cmd_crc !== 7'h44 || cmd_crc_ok !== BAD_CRC_OK) begin n_bad++; $display("FAIL cmd8_bad got %h/%b want 44/%b", cmd_crc, cmd_crc_ok, BAD_CRC_OK); end
    n_cmp++; if (frames - f0 !== 3) begin n_bad++; $display("FAIL b2b_frames got %0d want 3", frames - f0); end
    cs_high();
  endtask

  task automatic test_miso_fifo();
    logic [7:0] r;
    logic [23:0] exp_b;
    exp_b = 24'h01_00_FF;
    push(8'h01); push(8'h00);
    n_cmp++; if (rsp_full !== 1'b0) begin n_bad++; $display("FAIL fifo2_full got %b want 0", rsp_full); end
    cs_low();
    for (int i = 0; i < 3; i++) begin
      spi_xfer(8'hFF, 8, r);
      n_cmp++; if (r !== exp_b[23-8*i -: 8]) begin n_bad++; $display("FAIL miso_byte%0d got %h want %h", i, r, exp_b[23-8*i -: 8]); end
    end
    cs_high();
  endtask

  task automatic test_overrun();
    int f0, o0;
    logic [7:0] r;
    logic [47:0] fr;
    f0 = frames; o0 = ovr_cnt;
    cmd_ready = 1'b0;
    cs_low();
    send_frame(48'h40_00000000_95);
    fr = 48'h51_00000200_FF;
    for (int i = 0; i < 5; i++) spi_xfer(fr[47-8*i -: 8], 8, r);
    repeat (4) @(negedge clock);
    n_cmp++; if (ovr_cnt - o0 !== 0) begin n_bad++; $display("FAIL ovr_early got %0d want 0", ovr_cnt - o0); end
    spi_xfer(fr[7:0], 8, r);
    repeat (4) @(negedge clock);
    n_cmp++; if (ovr_cnt - o0 !== 1) begin n_bad++; $display("FAIL ovr_count got %0d want 1", ovr_cnt - o0); end
    n_cmp++; if (cmd_valid !== 1'b1 || cmd_idx !== 6'd0 || cmd_arg !== 32'd0 || cmd_crc !== 7'h4A) begin n_bad++; $display("FAIL ovr_kept got %b %h %h %h want 1 00 00000000 4a", cmd_valid, cmd_idx, cmd_arg, cmd_crc); end
    n_cmp++; if (frames - f0 !== 1) begin n_bad++; $display("FAIL ovr_frames got %0d want 1", frames - f0); end
    cmd_ready = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_release got %b want 0", cmd_valid); end
    cs_high();
  endtask

  task automatic test_abort();
    int f0, s0;
    logic [7:0] r;
    f0 = frames; s0 = stb_cnt;
    cs_low();
    spi_xfer(8'h48, 8, r);
    spi_xfer(8'h00, 8, r);
    spi_xfer(8'h00, 3, r);
    cs_high();
    cs_low();
    send_frame(48'h51_00000200_FF);
    cs_high();
    n_cmp++; if (frames - f0 !== 1) begin n_bad++; $display("FAIL abort_frames got %0d want 1", frames - f0); end
    n_cmp++; if (cmd_idx !== 6'd17 || cmd_arg !== 32'h200) begin n_bad++; $display("FAIL abort_cmd17 got %h %h want 11 00000200", cmd_idx, cmd_arg); end
    n_cmp++; if (stb_cnt - s0 !== 8) begin n_bad++; $display("FAIL abort_stb got %0d want 8", stb_cnt - s0); end
  endtask

  task automatic test_full_and_reset();
    logic [7:0] r;
    logic [39:0] exp_b;
    exp_b = 40'hAA_BB_CC_DD_FF;
    push(8'hAA); push(8'hBB); push(8'hCC);
    n_cmp++; if (rsp_full !== 1'b0) begin n_bad++; $display("FAIL full_at3 got %b want 0", rsp_full); end
    push(8'hDD);
    n_cmp++; if (rsp_full !== 1'b1) begin n_bad++; $display("FAIL full_at4 got %b want 1", rsp_full); end
    push(8'hEE);
    cs_low();
    for (int i = 0; i < 5; i++) begin
      spi_xfer(8'hFF, 8, r);
      n_cmp++; if (r !== exp_b[39-8*i -: 8]) begin n_bad++; $display("FAIL drain_byte%0d got %h want %h", i, r, exp_b[39-8*i -: 8]); end
    end
    cs_high();
    push(8'h11); push(8'h22); push(8'h33);
    cs_low();
    spi_xfer(8'hFF, 8, r);
    n_cmp++; if (r !== 8'h11) begin n_bad++; $display("FAIL pre_reset_byte got %h want 11", r); end
    spi_xfer(8'h00, 3, r);
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++; if (miso !== 1'b1 || rsp_full !== 1'b0 || rx_stb !== 1'b0) begin n_bad++; $display("FAIL midreset got %b%b%b want 100", miso, rsp_full, rx_stb); end
    cs = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    cs_low();
    spi_xfer(8'hFF, 8, r);
    n_cmp++; if (r !== 8'hFF) begin n_bad++; $display("FAIL post_reset_empty got %h want ff", r); end
    cs_high();
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    test_reset();
    test_cmd0_cmd8();
    test_miso_fifo();
    test_overrun();
    test_abort();
    test_full_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
